// File: rtl/f_pc_unit.sv
// Fetch PC register: next PC is combinational onto imem_addr, F_pc follows one cycle later.
// Stalls (en=0) hold the PC and park any redirect so it is applied on the next enabled cycle.
module f_pc_unit #(
  parameter logic [31:0] RESET_PC   = 32'h8000_0000,
  parameter logic [31:0] EXC_VECTOR = 32'h8000_0180
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic        exc_req,
  input  logic        eret_req,
  input  logic [31:0] epc,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic [31:0] imem_addr,
  output logic [31:0] F_pc,
  output logic [4:0]  F_exc_code,
  output logic        pend_valid
);

  localparam logic [4:0] EXC_ADEL = 5'd4;

  logic [31:0] pc;
  logic [31:0] pend_target;
  logic [31:0] next_pc;
  logic        next_pend_valid;
  logic [31:0] next_pend_target;

  // Exception and ERET bypass the stall; everything else waits for en.
  always_comb begin
    next_pc          = pc;
    next_pend_valid  = pend_valid;
    next_pend_target = pend_target;
    if (exc_req) begin
      next_pc         = EXC_VECTOR;
      next_pend_valid = 1'b0;
    end else if (eret_req) begin
      next_pc         = epc;
      next_pend_valid = 1'b0;
    end else if (en) begin
      next_pend_valid = 1'b0;
      if (redirect_valid) begin
        next_pc = redirect_target;
      end else if (pend_valid) begin
        next_pc = pend_target;
      end else begin
        next_pc = pc + 32'd4;
      end
    end else if (redirect_valid) begin
      next_pend_valid  = 1'b1;
      next_pend_target = redirect_target;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc          <= RESET_PC;
      pend_valid  <= 1'b0;
      pend_target <= 32'h0;
    end else begin
      pc          <= next_pc;
      pend_valid  <= next_pend_valid;
      pend_target <= next_pend_target;
    end
  end

  // The synchronous IM must see the reset PC while reset is held.
  assign imem_addr  = reset ? RESET_PC : next_pc;
  assign F_pc       = pc;
  assign F_exc_code = (pc[1:0] != 2'b00) ? EXC_ADEL : 5'd0;

endmodule
